// File: rtl/alu_writeback_buffer.sv
// Writeback buffer behind the ALU: captures issued ops, derives {C,Z,N}, queues results toward the register file.
// Optional same-cycle bypass when the queue is empty is enabled with `define ALU_WB_BYPASS_EN.
module alu_writeback_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned RD_W  = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     issue_en,
   input  logic [RD_W-1:0]          issue_rd,
   input  logic [32:0]              aluout,
   input  logic                     wb_ready,
   output logic                     wb_valid,
   output logic [RD_W-1:0]          wb_rd,
   output logic [31:0]              wb_data,
   output logic [2:0]               wb_flags,
   output logic                     issue_stall,
   output logic                     overflow_err,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = RD_W + 35;
   localparam logic [CW:0] STALL_TH = (CW+1)'(DEPTH - 1);

   logic            p_vld_q;
   logic [RD_W-1:0] p_rd_q;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;
   logic [EW-1:0]   mem_q [DEPTH];

   logic [2:0]      cur_flags;
   logic [EW-1:0]   cur_entry;
   logic [EW-1:0]   out_entry;
   logic            out_valid;
   logic            push_req, full, fifo_pop, byp_take, push, drop;
   logic [CW:0]     stall_sum;

   always_comb begin
      cur_flags = {aluout[32], (aluout[31:0] == '0), aluout[31]};
      cur_entry = {p_rd_q, aluout[31:0], cur_flags};
      push_req  = p_vld_q && (p_rd_q != '0);
      full      = (count_q == CW'(DEPTH));
      fifo_pop  = (count_q != '0) && wb_ready;
      out_valid = (count_q != '0);
      out_entry = mem_q[rd_ptr_q];
      byp_take  = 1'b0;
`ifdef ALU_WB_BYPASS_EN
      // Empty queue: present the in-flight result directly; it is only queued if not taken now.
      if ((count_q == '0) && push_req) begin
         out_valid = 1'b1;
         out_entry = cur_entry;
         byp_take  = wb_ready;
      end
`endif
      push     = push_req && !byp_take && (!full || fifo_pop);
      drop     = push_req && full && !fifo_pop;
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(fifo_pop);
      count_d  = count_q;
      if (push && !fifo_pop) begin
         count_d = count_q + CW'(1);
      end else if (!push && fifo_pop) begin
         count_d = count_q - CW'(1);
      end
      ovf_d = ovf_q | drop;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p_vld_q  <= 1'b0;
         p_rd_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         p_vld_q  <= issue_en;
         p_rd_q   <= issue_rd;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset: outputs are masked whenever nothing valid is presented.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem_q[wr_ptr_q] <= cur_entry;
      end
   end

   always_comb begin
      stall_sum   = {1'b0, count_q} + {{CW{1'b0}}, p_vld_q};
      issue_stall = (stall_sum >= STALL_TH);
      wb_valid    = out_valid;
      {wb_rd, wb_data, wb_flags} = out_valid ? out_entry : '0;
      overflow_err = ovf_q;
      count        = count_q;
   end

endmodule
